// File: rtl/jpeg_rle_encoder.sv
// Streaming JPEG run-length/symbol encoder: zigzag coefficients in, DC / (run,value) / ZRL / EOB symbols out.
// A single registered output slot with ready/valid back-pressure; ZRL expansion stalls the input.
module jpeg_rle_encoder #(
  parameter int CW        = 12,
  parameter int BLOCK_LEN = 64,
  parameter int RUN_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [CW-1:0]     out_value,
  output logic              out_dc,
  output logic              out_zrl,
  output logic              out_eob,
  output logic              out_last
);

  localparam int IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int ZC_W  = $clog2(((BLOCK_LEN - 1) >> RUN_W) + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = '1;

  typedef enum logic [1:0] {ACCEPT, EMIT_ZRL, EMIT_SYM} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [RUN_W-1:0]  zrun_reg, zrun_next;
  logic [ZC_W-1:0]   zrl_cnt_reg, zrl_cnt_next;
  logic [CW-1:0]     hold_value_reg, hold_value_next;
  logic [RUN_W-1:0]  hold_run_reg, hold_run_next;
  logic              hold_last_reg, hold_last_next;
  logic              out_valid_reg, out_valid_next;
  logic [RUN_W-1:0]  out_run_reg, out_run_next;
  logic [CW-1:0]     out_value_reg, out_value_next;
  logic              out_dc_reg, out_dc_next;
  logic              out_zrl_reg, out_zrl_next;
  logic              out_eob_reg, out_eob_next;
  logic              out_last_reg, out_last_next;
  logic              in_xfer, out_xfer, is_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ACCEPT;
      idx_reg        <= '0;
      zrun_reg       <= '0;
      zrl_cnt_reg    <= '0;
      hold_value_reg <= '0;
      hold_run_reg   <= '0;
      hold_last_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_run_reg    <= '0;
      out_value_reg  <= '0;
      out_dc_reg     <= 1'b0;
      out_zrl_reg    <= 1'b0;
      out_eob_reg    <= 1'b0;
      out_last_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      zrun_reg       <= zrun_next;
      zrl_cnt_reg    <= zrl_cnt_next;
      hold_value_reg <= hold_value_next;
      hold_run_reg   <= hold_run_next;
      hold_last_reg  <= hold_last_next;
      out_valid_reg  <= out_valid_next;
      out_run_reg    <= out_run_next;
      out_value_reg  <= out_value_next;
      out_dc_reg     <= out_dc_next;
      out_zrl_reg    <= out_zrl_next;
      out_eob_reg    <= out_eob_next;
      out_last_reg   <= out_last_next;
    end
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_reg && out_ready;
  assign is_last  = (idx_reg == LAST_IDX);

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    zrun_next       = zrun_reg;
    zrl_cnt_next    = zrl_cnt_reg;
    hold_value_next = hold_value_reg;
    hold_run_next   = hold_run_reg;
    hold_last_next  = hold_last_reg;
    out_valid_next  = out_valid_reg;
    out_run_next    = out_run_reg;
    out_value_next  = out_value_reg;
    out_dc_next     = out_dc_reg;
    out_zrl_next    = out_zrl_reg;
    out_eob_next    = out_eob_reg;
    out_last_next   = out_last_reg;
    case (state_reg)
      ACCEPT: begin
        if (out_xfer) out_valid_next = 1'b0;
        if (in_xfer) begin
          idx_next      = is_last ? '0 : idx_reg + 1'b1;
          out_run_next  = '0;
          out_value_next = in_data;
          out_dc_next   = 1'b0;
          out_zrl_next  = 1'b0;
          out_eob_next  = 1'b0;
          out_last_next = 1'b0;
          if (idx_reg == '0) begin
            out_valid_next = 1'b1;
            out_dc_next    = 1'b1;
          end else if (in_data == '0) begin
            if (zrun_reg == RUN_MAX) begin
              zrl_cnt_next = zrl_cnt_reg + 1'b1;
              zrun_next    = '0;
            end else begin
              zrun_next = zrun_reg + 1'b1;
            end
            // Trailing zeros of any length collapse into one EOB.
            if (is_last) begin
              out_valid_next = 1'b1;
              out_eob_next   = 1'b1;
              out_last_next  = 1'b1;
              zrun_next      = '0;
              zrl_cnt_next   = '0;
            end
          end else if (zrl_cnt_reg == '0) begin
            out_valid_next = 1'b1;
            out_run_next   = zrun_reg;
            out_last_next  = is_last;
            zrun_next      = '0;
          end else begin
            // Park the symbol; pending ZRLs must go out first.
            hold_value_next = in_data;
            hold_run_next   = zrun_reg;
            hold_last_next  = is_last;
            out_valid_next  = 1'b1;
            out_run_next    = RUN_MAX;
            out_value_next  = '0;
            out_zrl_next    = 1'b1;
            state_next      = EMIT_ZRL;
          end
        end
      end
      EMIT_ZRL: begin
        if (out_xfer) begin
          zrl_cnt_next = zrl_cnt_reg - 1'b1;
          if (zrl_cnt_reg == ZC_W'(1)) begin
            out_run_next   = hold_run_reg;
            out_value_next = hold_value_reg;
            out_zrl_next   = 1'b0;
            out_last_next  = hold_last_reg;
            state_next     = EMIT_SYM;
          end
        end
      end
      EMIT_SYM: begin
        if (out_xfer) begin
          out_valid_next = 1'b0;
          zrun_next      = '0;
          state_next     = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state_reg == ACCEPT) && (!out_valid_reg || out_ready);
    out_valid = out_valid_reg;
    out_run   = out_run_reg;
    out_value = out_value_reg;
    out_dc    = out_dc_reg;
    out_zrl   = out_zrl_reg;
    out_eob   = out_eob_reg;
    out_last  = out_last_reg;
  end

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Scoreboard bench for jpeg_rle_encoder: a reference model queues expected symbols per block,
// a monitor pops and compares them on every output transfer.
module tb_jpeg_rle_encoder;

  localparam int CW = 12;
  localparam int BL = 64;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_run;
  logic [CW-1:0] out_value;
  logic          out_dc, out_zrl, out_eob, out_last;

  jpeg_rle_encoder #(.CW(CW), .BLOCK_LEN(BL), .RUN_W(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_run(out_run), .out_value(out_value),
    .out_dc(out_dc), .out_zrl(out_zrl), .out_eob(out_eob), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [19:0] exp_q[$];
  logic signed [CW-1:0] blk [BL];
  int  in_wait_cycles;
  bit  rand_bp   = 0;
  bit  stall_arm = 0;
  int  stall_cnt = 0;
  bit  mon_en    = 0;
  bit  prev_held = 0;
  logic [19:0] prev_pack;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [19:0] sym(input bit dc, input bit zrl, input bit eob, input bit last,
                                      input int run, input logic [CW-1:0] value);
    logic [RW-1:0] r;
    r = RW'(run);
    return {dc, zrl, eob, last, r, value};
  endfunction

  // Reference model: queue the symbols one block should produce.
  task automatic model_block();
    int zeros = 0;
    exp_q.push_back(sym(1, 0, 0, 0, 0, blk[0]));
    for (int i = 1; i < BL; i++) begin
      if (blk[i] == 0) zeros++;
      else begin
        while (zeros >= 16) begin
          exp_q.push_back(sym(0, 1, 0, 0, 15, '0));
          zeros -= 16;
        end
        exp_q.push_back(sym(0, 0, 0, i == BL - 1, zeros, blk[i]));
        zeros = 0;
      end
    end
    if (blk[BL-1] == 0) exp_q.push_back(sym(0, 0, 1, 1, 0, '0));
  endtask

  task automatic drive(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
        w++;
        in_wait_cycles++;
        @(negedge clk);
      end
      if (!in_ready) begin
        check("in_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic clear_blk();
    for (int i = 0; i < BL; i++) blk[i] = '0;
  endtask

  function automatic logic [CW-1:0] rand_nz();
    logic [CW-1:0] v;
    v = CW'($urandom_range(1, 2047));
    if ($urandom_range(1) == 1) v = -v;
    return v;
  endfunction

  // Downstream ready: scripted 5-cycle stall on a ZRL, optional random back-pressure.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (stall_arm && out_valid && out_zrl) begin
      stall_arm = 0;
      out_ready = 1'b0;
      stall_cnt = 4;
    end else begin
      out_ready = rand_bp ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Monitor: one line per symbol transfer, hold-stability while stalled.
  always @(negedge clk) begin
    logic [19:0] cur;
    logic [19:0] e;
    cur = {out_dc, out_zrl, out_eob, out_last, out_run, out_value};
    if (mon_en) begin
      if (prev_held) begin
        check("hold_valid", out_valid, 1);
        check("hold_stable", cur, prev_pack);
        if (out_zrl) check("zrl_in_ready_low", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_symbol", cur, 20'h0);
        else begin
          e = exp_q.pop_front();
          $display("sym run=%0d value=%0d dc=%0b zrl=%0b eob=%0b last=%0b", out_run,
                   $signed(out_value), out_dc, out_zrl, out_eob, out_last);
          check("symbol", cur, e);
        end
      end
    end
    prev_held = out_valid && !out_ready;
    prev_pack = cur;
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // DC only, trailing zeros -> DC + EOB
    clear_blk(); blk[0] = 12'sd5;
    model_block(); drive(BL); drain();

    // One ZRL before idx 20
    clear_blk(); blk[0] = -12'sd2; blk[20] = -12'sd3;
    in_wait_cycles = 0;
    model_block(); drive(BL); drain();
    check("zrl_stall_seen", in_wait_cycles > 0, 1);

    // Three ZRLs, nonzero last coefficient, no EOB
    clear_blk(); blk[0] = 12'sd1; blk[63] = 12'sd7;
    model_block(); drive(BL); drain();

    // Same as the ZRL case with downstream stalled during the ZRL
    clear_blk(); blk[0] = -12'sd2; blk[20] = -12'sd3;
    stall_arm = 1;
    model_block(); drive(BL); drain();
    check("stall_fired", stall_arm, 0);

    // Reset mid-block at idx 30 (zrl_cnt=1 pending)
    clear_blk(); blk[0] = 12'sd8;
    exp_q.push_back(sym(1, 0, 0, 0, 0, blk[0]));
    drive(30);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    clear_blk(); blk[0] = 12'sd9; blk[1] = 12'sd4;
    model_block(); drive(BL); drain();

    // Two back-to-back fully nonzero blocks at full rate
    in_wait_cycles = 0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BL; i++) blk[i] = rand_nz();
      model_block(); drive(BL);
    end
    drain();
    check("full_rate_no_stall", in_wait_cycles, 0);

    // Random sparse blocks under random back-pressure
    rand_bp = 1;
    for (int b = 0; b < 4; b++) begin
      clear_blk();
      for (int i = 0; i < BL; i++)
        if ($urandom_range(9) == 0 || i == 0) blk[i] = rand_nz();
      model_block(); drive(BL);
    end
    drain();
    rand_bp = 0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
